ram_16x8: RTL and testbench

RAM_16X8 -- requirements
Module: ram_16x8

---
 rtl/ram_16x8.sv | 86 ++++++++
 tb/tb_ram_16x8.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_16x8.sv
// rtl/ram_16x8.sv - 16x8 program-loadable RAM with tri-state W-bus read port
module ram_16x8 (
    input  logic       CLK,
    input  logic       CLR_bar,
    input  logic [3:0] ram_addr,
    input  logic       CE_bar,
    input  logic       PROG,
    input  logic [7:0] prog_data,
    input  logic       prog_valid,
    output logic       prog_ready,
    output logic       prog_done,
    output logic [3:0] prog_addr,
    output wire  [7:0] ram_output
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_prog_addr;
    logic [3:0] w_next_addr;
    logic [7:0] r_mem [16];
    logic       w_accept;

    // A falling PROG wins over a coincident valid word, so the write is gated on PROG too.
    assign w_accept = (r_state == LOAD) && PROG && prog_valid;

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            r_state     <= RUN;
            r_prog_addr <= 4'd0;
        end else begin
            r_state     <= w_next_state;
            r_prog_addr <= w_next_addr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_prog_addr;
        prog_ready   = 1'b0;
        prog_done    = 1'b0;
        case (r_state)
            RUN: begin
                if (PROG) begin
                    w_next_state = LOAD;
                    w_next_addr  = 4'd0;
                end
            end
            LOAD: begin
                prog_ready = 1'b1;
                if (!PROG) begin
                    w_next_state = RUN;
                end else if (prog_valid) begin
                    w_next_addr = 4'(r_prog_addr + 4'd1);
                    if (r_prog_addr == 4'd15) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                prog_done = 1'b1;
                if (!PROG) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    // Storage has no reset so program contents survive CLR_bar.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem[r_prog_addr] <= prog_data;
        end
    end

    assign prog_addr  = r_prog_addr;
    assign ram_output = ((r_state == RUN) && !CE_bar) ? r_mem[ram_addr] : 8'bz;

endmodule

// File: tb/tb_ram_16x8.sv
// tb/tb_ram_16x8.sv - self-checking bench for ram_16x8 with a write scoreboard
module tb_ram_16x8;
    logic       CLK = 1'b0;
    logic       CLR_bar;
    logic [3:0] ram_addr;
    logic       CE_bar;
    logic       PROG;
    logic [7:0] prog_data;
    logic       prog_valid;
    logic       prog_ready;
    logic       prog_done;
    logic [3:0] prog_addr;
    wire  [7:0] w_bus;

    // A second driver on the bus reveals whether the DUT has released it.
    logic       tb_drv_en;
    logic [7:0] tb_drv;
    assign w_bus = tb_drv_en ? tb_drv : 8'bz;

    ram_16x8 dut (
        .CLK        (CLK),
        .CLR_bar    (CLR_bar),
        .ram_addr   (ram_addr),
        .CE_bar     (CE_bar),
        .PROG       (PROG),
        .prog_data  (prog_data),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_addr  (prog_addr),
        .ram_output (w_bus)
    );

    always #10 CLK = ~CLK;

    typedef enum {M_RUN, M_LOAD, M_DONE} mstate_t;
    mstate_t     m_state;
    logic [3:0]  m_addr;
    logic [11:0] sb_q [$];
    int          n_pass;
    int          n_total;

    // One clock of stimulus; accepted writes are pushed as {addr, data}.
    task automatic drive(input logic p, input logic v, input logic [7:0] d);
        PROG       = p;
        prog_valid = v;
        prog_data  = d;
        @(posedge CLK);
        case (m_state)
            M_RUN: if (p) begin
                m_state = M_LOAD;
                m_addr  = 4'd0;
            end
            M_LOAD: if (!p) begin
                m_state = M_RUN;
            end else if (v) begin
                sb_q.push_back({m_addr, d});
                if (m_addr == 4'd15) m_state = M_DONE;
                m_addr = 4'(m_addr + 4'd1);
            end
            M_DONE: if (!p) m_state = M_RUN;
            default: m_state = M_RUN;
        endcase
        #1;
    endtask

    task automatic test_reset();
        CLR_bar = 1'b0; PROG = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        CE_bar = 1'b1; ram_addr = 4'd0; tb_drv_en = 1'b0; tb_drv = 8'h00;
        m_state = M_RUN; m_addr = 4'd0;
        #3;
        n_total++;
        if ({prog_ready, prog_done, prog_addr} !== 6'b00_0000)
            $display("FAIL reset_outputs: got ready=%b done=%b addr=%0d expected 0 0 0", prog_ready, prog_done, prog_addr);
        else n_pass++;
        tb_drv = 8'h5A; tb_drv_en = 1'b1; #1;
        n_total++;
        if (w_bus !== 8'h5A) $display("FAIL reset_bus_released: got %h expected 5a", w_bus);
        else n_pass++;
        tb_drv_en = 1'b0;
        @(negedge CLK);
        CLR_bar = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({prog_ready, prog_done} !== 2'b00)
            $display("FAIL reset_run_idle: got ready=%b done=%b expected 0 0", prog_ready, prog_done);
        else n_pass++;
    endtask

    task automatic test_full_load();
        logic [11:0] e;
        drive(1'b1, 1'b0, 8'h00);
        n_total++;
        if ({prog_ready, prog_done, prog_addr} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL load_entry: got ready=%b done=%b addr=%0d expected 1 0 0", prog_ready, prog_done, prog_addr);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 8'(8'h10 + i));
            if (i == 14) begin
                n_total++;
                if ({prog_ready, prog_done, prog_addr} !== {1'b1, 1'b0, 4'd15})
                    $display("FAIL load_word15: got ready=%b done=%b addr=%0d expected 1 0 15", prog_ready, prog_done, prog_addr);
                else n_pass++;
            end
        end
        n_total++;
        if ({prog_ready, prog_done, prog_addr} !== {1'b0, 1'b1, 4'd0})
            $display("FAIL load_done: got ready=%b done=%b addr=%0d expected 0 1 0", prog_ready, prog_done, prog_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({prog_ready, prog_done} !== 2'b00)
            $display("FAIL load_exit: got ready=%b done=%b expected 0 0", prog_ready, prog_done);
        else n_pass++;
        CE_bar = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ram_addr = e[11:8]; #1;
            n_total++;
            if (w_bus !== e[7:0]) $display("FAIL full_readback: addr %0d got %h expected %h", e[11:8], w_bus, e[7:0]);
            else n_pass++;
        end
        ram_addr = 4'd5; #1;
        n_total++;
        if (w_bus !== 8'h15) $display("FAIL full_addr5: got %h expected 15", w_bus);
        else n_pass++;
        CE_bar = 1'b1;
    endtask

    task automatic test_done_hold();
        logic [11:0] e;
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 8'(8'h40 + i));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 8'hEE);
            n_total++;
            if ({prog_ready, prog_done, prog_addr} !== {1'b0, 1'b1, 4'd0})
                $display("FAIL done_hold_%0d: got ready=%b done=%b addr=%0d expected 0 1 0", k, prog_ready, prog_done, prog_addr);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 8'h00);
        CE_bar = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ram_addr = e[11:8]; #1;
            n_total++;
            if (w_bus !== e[7:0]) $display("FAIL done_readback: addr %0d got %h expected %h", e[11:8], w_bus, e[7:0]);
            else n_pass++;
        end
        CE_bar = 1'b1;
    endtask

    task automatic test_gapped();
        logic [11:0] e;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hAA);
        drive(1'b1, 1'b0, 8'hBB);
        drive(1'b1, 1'b1, 8'hCC);
        n_total++;
        if ({prog_ready, prog_addr} !== {1'b1, 4'd2})
            $display("FAIL gapped_addr: got ready=%b addr=%0d expected 1 2", prog_ready, prog_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 8'h00);
        CE_bar = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ram_addr = e[11:8]; #1;
            n_total++;
            if (w_bus !== e[7:0]) $display("FAIL gapped_readback: addr %0d got %h expected %h", e[11:8], w_bus, e[7:0]);
            else n_pass++;
        end
        ram_addr = 4'd2; #1;
        n_total++;
        if (w_bus !== 8'h42) $display("FAIL gapped_addr2_kept: got %h expected 42", w_bus);
        else n_pass++;
        CE_bar = 1'b1;
    endtask

    task automatic test_abort();
        logic [11:0] e;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b1, 1'b1, 8'h02);
        drive(1'b1, 1'b1, 8'h03);
        drive(1'b0, 1'b1, 8'h04);
        prog_valid = 1'b0;
        n_total++;
        if ({prog_ready, prog_done, prog_addr} !== {1'b0, 1'b0, 4'd3})
            $display("FAIL abort_state: got ready=%b done=%b addr=%0d expected 0 0 3", prog_ready, prog_done, prog_addr);
        else n_pass++;
        CE_bar = 1'b0;
        ram_addr = 4'd3; #1;
        n_total++;
        if (w_bus !== 8'h43) $display("FAIL abort_addr3_kept: got %h expected 43", w_bus);
        else n_pass++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ram_addr = e[11:8]; #1;
            n_total++;
            if (w_bus !== e[7:0]) $display("FAIL abort_readback: addr %0d got %h expected %h", e[11:8], w_bus, e[7:0]);
            else n_pass++;
        end
        CE_bar = 1'b1;
    endtask

    task automatic test_tristate();
        logic [7:0] pat;
        CE_bar = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? 8'h5A : 8'hA5;
            tb_drv = pat; tb_drv_en = 1'b1; #1;
            n_total++;
            if (w_bus !== pat) $display("FAIL tristate_run_ce1: got %h expected %h", w_bus, pat);
            else n_pass++;
            tb_drv_en = 1'b0;
        end
        CE_bar = 1'b0;
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? 8'h5A : 8'hA5;
            tb_drv = pat; tb_drv_en = 1'b1; #1;
            n_total++;
            if (w_bus !== pat) $display("FAIL tristate_load_ce0: got %h expected %h", w_bus, pat);
            else n_pass++;
            tb_drv_en = 1'b0;
        end
        drive(1'b0, 1'b0, 8'h00);
        ram_addr = 4'd0; #1;
        n_total++;
        if (w_bus !== 8'h01) $display("FAIL tristate_run_ce0: got %h expected 01", w_bus);
        else n_pass++;
        CE_bar = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 8'(8'h70 + i));
        prog_valid = 1'b0;
        n_total++;
        if ({prog_ready, prog_addr} !== {1'b1, 4'd7})
            $display("FAIL areset_pre: got ready=%b addr=%0d expected 1 7", prog_ready, prog_addr);
        else n_pass++;
        #1;
        CLR_bar = 1'b0;
        m_state = M_RUN; m_addr = 4'd0;
        #1;
        n_total++;
        if ({prog_ready, prog_done, prog_addr} !== 6'b00_0000)
            $display("FAIL areset_immediate: got ready=%b done=%b addr=%0d expected 0 0 0", prog_ready, prog_done, prog_addr);
        else n_pass++;
        CE_bar = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ram_addr = e[11:8]; #1;
            n_total++;
            if (w_bus !== e[7:0]) $display("FAIL areset_readback: addr %0d got %h expected %h", e[11:8], w_bus, e[7:0]);
            else n_pass++;
        end
        CE_bar = 1'b1;
        CLR_bar = 1'b1;
        drive(1'b1, 1'b0, 8'h00);
        n_total++;
        if ({prog_ready, prog_addr} !== {1'b1, 4'd0})
            $display("FAIL areset_resume: got ready=%b addr=%0d expected 1 0", prog_ready, prog_addr);
        else n_pass++;
        drive(1'b1, 1'b1, 8'h99);
        n_total++;
        if (prog_addr !== 4'd1) $display("FAIL areset_next_addr: got %0d expected 1", prog_addr);
        else n_pass++;
        drive(1'b0, 1'b0, 8'h00);
        CE_bar = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ram_addr = e[11:8]; #1;
            n_total++;
            if (w_bus !== e[7:0]) $display("FAIL areset_overwrite: addr %0d got %h expected %h", e[11:8], w_bus, e[7:0]);
            else n_pass++;
        end
        ram_addr = 4'd1; #1;
        n_total++;
        if (w_bus !== 8'h71) $display("FAIL areset_addr1_kept: got %h expected 71", w_bus);
        else n_pass++;
        CE_bar = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_full_load();
        test_done_hold();
        test_gapped();
        test_abort();
        test_tristate();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
